sw_query_feeder: RTL and testbench
==================================

Name: sw_query_feeder

Overview:
- Downstream neighbour of the symbol-packing stage.
- Captures one packed word of 4-bit nucleotide symbols (oldest symbol in the MS nibble) when the packer presents it, and streams the symbols one per transfer into the Smith-Waterman PE array under a valid/ready handshake.
- Drives the "PE empty" indication back to the packer, so a new word is only taken once the previous sequence has fully drained.
- Optionally terminates a sequence early at a pad symbol, and reports the sequence length.

Parameters:
- SYM_WIDTH, 4, bits per symbol.
- WORD_WIDTH, 252, packed word width; must be an integer multiple of SYM_WIDTH.
- SYMS, WORD_WIDTH/SYM_WIDTH (63), symbols per word.
- IDX_W, 6, width of the symbol index; 2^IDX_W >= SYMS.
- PAD_EN, 1, 1 = a symbol equal to PAD_SYM ends the sequence.
- PAD_SYM, 0, pad/terminator symbol code.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- word_in  in  WORD_WIDTH  packed symbols; symbol 0 = word_in[WORD_WIDTH-1 -: SYM_WIDTH].
- word_valid  in  1  word_in valid this cycle (packer's ready flag).
- feeder_empty  out  1  feeder idle and able to capture; drives packer's PE-empty input.
- sym_out  out  SYM_WIDTH  current symbol to the PE array.
- sym_valid  out  1  sym_out valid.
- sym_ready  in  1  PE array accepts sym_out this cycle.
- sym_idx  out  IDX_W  position of sym_out within the word (0-based).
- sym_last  out  1  sym_out is the final symbol of this sequence.
- seq_done  out  1  one-cycle pulse: sequence finished.
- seq_len  out  IDX_W+1  number of symbols transferred; valid while seq_done=1.

Behaviour:
- All outputs are registered.
- Reset values: feeder_empty=1 and seq_done=0. Every other output is 0, including sym_out, sym_valid, sym_idx, sym_last and seq_len. The held word register is also 0.
- Reset is honoured in any state, including mid-stream. The current word is discarded and the FSM goes to IDLE.
- States: IDLE, STREAM, DONE.
- IDLE:
  - feeder_empty=1, sym_valid=0.
  - If word_valid=1 on a rising edge, capture word_in into the hold register and clear the transfer count.
  - Normal capture: next state is STREAM, with sym_valid=1, sym_idx=0, sym_out=symbol 0 and feeder_empty=0.
  - Pad-first capture (PAD_EN=1 and symbol 0 == PAD_SYM): next state is DONE with seq_len=0. No sym_valid is ever raised.
- STREAM:
  - A transfer occurs on any edge where sym_valid & sym_ready.
  - Without a transfer, sym_out, sym_idx and sym_last hold stable.
  - sym_last=1 when sym_idx==SYMS-1, or when PAD_EN=1 and symbol sym_idx+1 == PAD_SYM. It is computed by lookahead and registered together with sym_out.
  - Transfer with sym_last=0: sym_idx increments and the next symbol is loaded. Throughput is one symbol per cycle while sym_ready=1.
  - Transfer with sym_last=1: sym_valid drops, seq_len = sym_idx+1, and the next state is DONE.
- DONE:
  - seq_done=1 for exactly one cycle; seq_len is presented in the same cycle.
  - Next state is IDLE, where feeder_empty returns to 1.
  - seq_len holds its value until the next seq_done.
- word_valid is ignored in STREAM and DONE; there is no capture and no error.
  - The packer only raises word_valid when feeder_empty=1, so this case is protective only.
- Latency:
  - Capture edge to first sym_valid: 1 cycle.
  - Last transfer edge to seq_done: 1 cycle.
  - seq_done to feeder_empty=1: 1 cycle.
  - Minimum occupancy for a full word: SYMS+2 cycles.
- sym_ready is ignored while sym_valid=0.
- sym_idx never wraps. Its maximum value is SYMS-1.

Test Plan:
- Full word, sym_ready tied 1. Nibbles 1,2,…,F repeating, no zeros, word_valid pulsed in IDLE → 63 consecutive sym_valid cycles with sym_out 1,2,3,… and sym_idx 0..62. sym_last=1 only at idx 62. seq_done pulses the next cycle with seq_len=63, and feeder_empty=1 one cycle later.
- Backpressure. Same word, sym_ready toggled 1,0,0,1,… → sym_out and sym_idx are stable during low-ready cycles. Exactly 63 transfers in order, no duplicates or drops, seq_len=63.
- Pad termination, PAD_EN=1. Symbols 0..9 = 3, symbol 10 = 0 → 10 transfers of value 3. sym_last is set at idx 9, then seq_done with seq_len=10.
- Pad-first. Symbol 0 = 0 → sym_valid never asserts. seq_done pulses one cycle after capture with seq_len=0, and feeder_empty=1 on the following cycle.
- Ignore while busy. A second word_valid with a different word at idx 5 → streamed symbols still come from the first word, and the second word is never emitted.
- Reset mid-stream. rst asserted asynchronously at idx 20 → all outputs take reset values immediately, including feeder_empty=1. The next word after reset streams from idx 0.

Source files
------------

// File: rtl/sw_query_feeder.sv
// sw_query_feeder: captures one packed word of nucleotide symbols from the
// packer and streams them, oldest first, into the Smith-Waterman PE array
// under a valid/ready handshake. A sequence may end early at a pad symbol.
//
// Ports:
//   clk          clock, all state on rising edge
//   rst          asynchronous active-high reset
//   word_in      packed symbols, symbol 0 in the MS nibble
//   word_valid   word_in valid (taken only while idle)
//   feeder_empty feeder idle and able to capture (PE-empty to the packer)
//   sym_out      current symbol to the PE array
//   sym_valid    sym_out valid
//   sym_ready    PE array accepts sym_out this cycle
//   sym_idx      0-based position of sym_out within the word
//   sym_last     sym_out is the final symbol of the sequence
//   seq_done     one-cycle pulse when the sequence has finished
//   seq_len      symbols transferred, presented with seq_done and held
module sw_query_feeder #(
    parameter int unsigned                 SYM_WIDTH  = 4,
    parameter int unsigned                 WORD_WIDTH = 252,
    parameter int unsigned                 IDX_W      = 6,
    parameter bit                          PAD_EN     = 1'b1,
    parameter logic [SYM_WIDTH-1:0]        PAD_SYM    = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] word_in,
    input  logic                  word_valid,
    output logic                  feeder_empty,
    output logic [SYM_WIDTH-1:0]  sym_out,
    output logic                  sym_valid,
    input  logic                  sym_ready,
    output logic [IDX_W-1:0]      sym_idx,
    output logic                  sym_last,
    output logic                  seq_done,
    output logic [IDX_W:0]        seq_len
);

    localparam int unsigned SYMS = WORD_WIDTH / SYM_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [WORD_WIDTH-1:0]  word_q, word_d;
    logic [SYM_WIDTH-1:0]   sym_out_q, sym_out_d;
    logic                   sym_valid_q, sym_valid_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   last_q, last_d;
    logic                   seq_done_q, seq_done_d;
    logic [IDX_W:0]         seq_len_q, seq_len_d;
    logic                   empty_q, empty_d;

    logic [IDX_W:0]         idx_inc;
    logic [SYM_WIDTH-1:0]   first_sym;

    // Symbol k of a word: shift it up into the MS position and take the top nibble.
    function automatic logic [SYM_WIDTH-1:0] sym_at(input logic [WORD_WIDTH-1:0] w,
                                                    input logic [IDX_W:0]        k);
        logic [WORD_WIDTH-1:0] sh;
        sh = w << (32'(k) * SYM_WIDTH);
        return sh[WORD_WIDTH-1 -: SYM_WIDTH];
    endfunction

    // Lookahead: symbol k ends the sequence if it is the last slot or the next one is a pad.
    function automatic logic last_at(input logic [WORD_WIDTH-1:0] w,
                                     input logic [IDX_W:0]        k);
        logic r;
        if (k == (IDX_W+1)'(SYMS - 1)) begin
            r = 1'b1;
        end else begin
            r = PAD_EN && (sym_at(w, k + (IDX_W+1)'(1)) == PAD_SYM);
        end
        return r;
    endfunction

    assign idx_inc   = (IDX_W+1)'(idx_q) + (IDX_W+1)'(1);
    assign first_sym = sym_at(word_in, '0);

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            word_q      <= '0;
            sym_out_q   <= '0;
            sym_valid_q <= 1'b0;
            idx_q       <= '0;
            last_q      <= 1'b0;
            seq_done_q  <= 1'b0;
            seq_len_q   <= '0;
            empty_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            sym_out_q   <= sym_out_d;
            sym_valid_q <= sym_valid_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            seq_done_q  <= seq_done_d;
            seq_len_q   <= seq_len_d;
            empty_q     <= empty_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        sym_out_d   = sym_out_q;
        sym_valid_d = sym_valid_q;
        idx_d       = idx_q;
        last_d      = last_q;
        seq_done_d  = 1'b0;
        seq_len_d   = seq_len_q;
        empty_d     = empty_q;

        case (state_q)
            S_IDLE: begin
                empty_d     = 1'b1;
                sym_valid_d = 1'b0;
                if (word_valid) begin
                    word_d  = word_in;
                    idx_d   = '0;
                    empty_d = 1'b0;
                    if (PAD_EN && (first_sym == PAD_SYM)) begin
                        // Empty sequence: report length 0 without raising sym_valid.
                        state_d    = S_DONE;
                        seq_done_d = 1'b1;
                        seq_len_d  = '0;
                    end else begin
                        state_d     = S_STREAM;
                        sym_out_d   = first_sym;
                        sym_valid_d = 1'b1;
                        last_d      = last_at(word_in, '0);
                    end
                end
            end

            S_STREAM: begin
                if (sym_valid_q && sym_ready) begin
                    if (last_q) begin
                        state_d     = S_DONE;
                        sym_valid_d = 1'b0;
                        seq_done_d  = 1'b1;
                        seq_len_d   = idx_inc;
                    end else begin
                        idx_d     = IDX_W'(idx_inc);
                        sym_out_d = sym_at(word_q, idx_inc);
                        last_d    = last_at(word_q, idx_inc);
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                empty_d = 1'b1;
            end

            default: begin
                state_d     = S_IDLE;
                sym_valid_d = 1'b0;
                empty_d     = 1'b1;
            end
        endcase
    end

    assign feeder_empty = empty_q;
    assign sym_out      = sym_out_q;
    assign sym_valid    = sym_valid_q;
    assign sym_idx      = idx_q;
    assign sym_last     = last_q;
    assign seq_done     = seq_done_q;
    assign seq_len      = seq_len_q;

endmodule

// File: tb/tb_sw_query_feeder.sv
// Scoreboard bench for sw_query_feeder: stimulus pushes expected transfers and
// sequence lengths; a monitor pops and compares on every transfer / seq_done.
module tb_sw_query_feeder;

    localparam int unsigned WW = 252;

    typedef struct packed {
        logic [3:0] s;
        logic [5:0] i;
        logic       l;
    } xfer_t;

    logic          clk;
    logic          rst;
    logic [WW-1:0] word_in;
    logic          word_valid;
    logic          feeder_empty;
    logic [3:0]    sym_out;
    logic          sym_valid;
    logic          sym_ready;
    logic [5:0]    sym_idx;
    logic          sym_last;
    logic          seq_done;
    logic [6:0]    seq_len;

    sw_query_feeder dut (
        .clk          (clk),
        .rst          (rst),
        .word_in      (word_in),
        .word_valid   (word_valid),
        .feeder_empty (feeder_empty),
        .sym_out      (sym_out),
        .sym_valid    (sym_valid),
        .sym_ready    (sym_ready),
        .sym_idx      (sym_idx),
        .sym_last     (sym_last),
        .seq_done     (seq_done),
        .seq_len      (seq_len)
    );

    int    n_checks = 0;
    int    n_fail   = 0;
    xfer_t exp_q[$];
    int    exp_len_q[$];
    int    rmode = 0;
    int    rcyc  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [WW-1:0] make_word(input int kind);
        logic [WW-1:0] w;
        int v;
        w = '0;
        for (int i = 0; i < 63; i++) begin
            case (kind)
                0: v = (i % 15) + 1;
                1: v = (i < 10) ? 3 : ((i == 10) ? 0 : 5);
                2: v = (i == 0) ? 0 : 7;
                default: v = 9;
            endcase
            w[WW-1-4*i -: 4] = 4'(v);
        end
        return w;
    endfunction

    // Reference: walk symbols until the pad or the end of the word.
    task automatic push_expect(input logic [WW-1:0] w);
        logic [3:0] s;
        logic [3:0] nx;
        xfer_t      x;
        for (int i = 0; i < 63; i++) begin
            s = w[WW-1-4*i -: 4];
            if (s == 4'd0) break;
            if (i == 62) nx = 4'd0;
            else         nx = w[WW-1-4*(i+1) -: 4];
            x.s = s;
            x.i = 6'(i);
            x.l = (i == 62) || (nx == 4'd0);
            exp_q.push_back(x);
            if (x.l) break;
        end
    endtask

    // sym_ready pattern: tied high, or 1,0,0 repeating.
    always @(posedge clk) begin
        #1;
        rcyc++;
        if (rmode == 0) sym_ready = 1'b1;
        else            sym_ready = ((rcyc % 3) == 0);
    end

    // Monitor: transfers, stall stability and sequence completion.
    logic       prev_stall = 1'b0;
    logic [3:0] prev_sym;
    logic [5:0] prev_idx;
    logic       prev_last;
    always @(negedge clk) begin
        xfer_t x;
        int    l;
        if (!rst) begin
            if (prev_stall && sym_valid) begin
                check("stall_sym", int'(sym_out), int'(prev_sym));
                check("stall_idx", int'(sym_idx), int'(prev_idx));
                check("stall_last", int'(sym_last), int'(prev_last));
            end
            if (sym_valid && sym_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_xfer", int'(sym_out), -1);
                end else begin
                    x = exp_q.pop_front();
                    check("xfer_sym", int'(sym_out), int'(x.s));
                    check("xfer_idx", int'(sym_idx), int'(x.i));
                    check("xfer_last", int'(sym_last), int'(x.l));
                end
            end
            if (seq_done) begin
                if (exp_len_q.size() == 0) begin
                    check("unexpected_done", int'(seq_len), -1);
                end else begin
                    l = exp_len_q.pop_front();
                    check("seq_len", int'(seq_len), l);
                    check("done_empty_low", int'(feeder_empty), 0);
                    check("done_no_valid", int'(sym_valid), 0);
                end
            end
        end
        prev_stall = sym_valid && !sym_ready && !rst;
        prev_sym   = sym_out;
        prev_idx   = sym_idx;
        prev_last  = sym_last;
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_empty"}, int'(feeder_empty), 1);
        check({tag, "_done"}, int'(seq_done), 0);
        check({tag, "_valid"}, int'(sym_valid), 0);
        check({tag, "_sym"}, int'(sym_out), 0);
        check({tag, "_idx"}, int'(sym_idx), 0);
        check({tag, "_last"}, int'(sym_last), 0);
        check({tag, "_len"}, int'(seq_len), 0);
    endtask

    // Present a word for one edge and check first-cycle latency.
    task automatic send_word(input logic [WW-1:0] w, input int len);
        push_expect(w);
        exp_len_q.push_back(len);
        @(posedge clk);
        #2;
        word_in    = w;
        word_valid = 1'b1;
        @(posedge clk);
        #2;
        word_valid = 1'b0;
        @(negedge clk);
        check("first_valid", int'(sym_valid), (len != 0) ? 1 : 0);
        check("capture_empty_low", int'(feeder_empty), 0);
        if (len == 0) check("padfirst_done", int'(seq_done), 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!seq_done && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!seq_done) check("done_timeout", 0, 1);
        @(negedge clk);
        check("post_done_empty", int'(feeder_empty), 1);
        check("post_done_pulse", int'(seq_done), 0);
    endtask

    task automatic wait_idx(input int target);
        int n = 0;
        while (!(sym_valid && int'(sym_idx) == target) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) check("idx_timeout", int'(sym_idx), target);
    endtask

    initial begin
        rst        = 1'b1;
        word_in    = '0;
        word_valid = 1'b0;
        sym_ready  = 1'b0;
        @(posedge clk);
        #2;
        check_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;

        // Full word, ready tied high.
        rmode = 0;
        send_word(make_word(0), 63);
        wait_done();

        // Backpressure 1,0,0 pattern.
        rmode = 1;
        send_word(make_word(0), 63);
        wait_done();
        rmode = 0;

        // Pad termination at symbol 10.
        send_word(make_word(1), 10);
        wait_done();

        // Pad as first symbol.
        send_word(make_word(2), 0);
        wait_done();

        // Second word offered while streaming is ignored.
        send_word(make_word(0), 63);
        wait_idx(5);
        #1;
        word_in    = make_word(3);
        word_valid = 1'b1;
        @(posedge clk);
        #2;
        word_valid = 1'b0;
        wait_done();

        // Asynchronous reset mid-stream, then a fresh word.
        send_word(make_word(0), 63);
        wait_idx(20);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        exp_q.delete();
        exp_len_q.delete();
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        send_word(make_word(1), 10);
        wait_done();

        repeat (3) @(negedge clk);
        check("leftover_xfers", exp_q.size(), 0);
        check("leftover_dones", exp_len_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
